poly_reg_bank_stream: RTL and testbench

// - Streaming operand/result register bank for the AMNS polynomial Montgomery multiplier; successor of the fixed-sequence operand bank.
// - Adds a valid/ready load engine with per-target word counting and a valid/ready result drain port.
// - Optionally double-buffers RES, so one result can be captured while the previous one drains.
// - Sits between the host word stream and the MAC datapath.

---
 rtl/poly_reg_bank_stream.sv | 246 ++++++++++++++++++++++++
 tb/tb_poly_reg_bank_stream.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/poly_reg_bank_stream.sv
// Streaming operand/result register bank for the AMNS polynomial Montgomery multiplier.
// Define RES_PINGPONG_EN to double-buffer RES so a new result can fill while the previous one drains.
module poly_reg_bank_stream #(
    parameter int WORD_WIDTH = 17,
    parameter int N          = 5,
    parameter int S          = 4
) (
    input  logic                    clock_i,
    input  logic                    reset_i,
    input  logic [1:0]              load_sel_i,
    input  logic                    load_start_i,
    input  logic                    load_valid_i,
    input  logic [WORD_WIDTH-1:0]   load_data_i,
    output logic                    load_ready_o,
    output logic                    load_done_o,
    input  logic [S-1:0]            A_reg_coeff_rot_i,
    input  logic                    B_reg_shift_i,
    input  logic                    M_reg_shift_i,
    input  logic                    M_prime_0_rot_i,
    output logic [S*WORD_WIDTH-1:0] A_reg_dout_o,
    output logic [N*WORD_WIDTH-1:0] B_reg_dout_o,
    output logic [WORD_WIDTH-1:0]   M_reg_dout_o,
    output logic [WORD_WIDTH-1:0]   M_prime_0_reg_dout_o,
    input  logic                    RES_wr_en_i,
    input  logic [WORD_WIDTH-1:0]   RES_din_i,
    output logic                    RES_wr_ready_o,
    output logic [WORD_WIDTH-1:0]   RES_dout_o,
    output logic                    RES_valid_o,
    input  logic                    RES_ready_i,
    output logic                    RES_last_o
);

    localparam int NS = N * S;
    localparam int CW = $clog2(NS);

`ifdef RES_PINGPONG_EN
    localparam logic PINGPONG = 1'b1;
`else
    localparam logic PINGPONG = 1'b0;
`endif

    // Handshake: a word moves on any rising edge where valid and ready are both high;
    // valid may not depend on ready, and data is held until the beat is taken.

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t                  state_q, state_d;
    logic [1:0]              sel_q, sel_d;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic [CW-1:0]           len_m1;
    logic                    load_beat;

    logic [WORD_WIDTH-1:0]   a_q [NS];
    logic [WORD_WIDTH-1:0]   a_d [NS];
    logic [WORD_WIDTH-1:0]   b_q [NS];
    logic [WORD_WIDTH-1:0]   b_d [NS];
    logic [WORD_WIDTH-1:0]   m_q [NS];
    logic [WORD_WIDTH-1:0]   m_d [NS];
    logic [WORD_WIDTH-1:0]   mp_q [N];
    logic [WORD_WIDTH-1:0]   mp_d [N];
    logic                    a_busy, b_busy, m_busy, mp_busy;

    // Buffer 1 is only ever addressed when the ping-pong pointers toggle.
    logic [WORD_WIDTH-1:0]   res_q [2][NS];
    logic [WORD_WIDTH-1:0]   res_d [2][NS];
    logic [1:0]              full_q, full_d;
    logic                    fill_ptr_q, fill_ptr_d;
    logic                    drain_ptr_q, drain_ptr_d;
    logic [CW-1:0]           fcnt_q, fcnt_d;
    logic [CW-1:0]           dcnt_q, dcnt_d;
    logic                    wr_fire, rd_fire;

    assign len_m1    = (sel_q == 2'b11) ? CW'(N - 1) : CW'(NS - 1);
    assign load_beat = (state_q == ST_LOAD) && load_valid_i;

    always_comb begin
        state_d      = state_q;
        sel_d        = sel_q;
        cnt_d        = cnt_q;
        load_ready_o = 1'b0;
        load_done_o  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (load_start_i) begin
                    state_d = ST_LOAD;
                    sel_d   = load_sel_i;
                    cnt_d   = '0;
                end
            end
            ST_LOAD: begin
                load_ready_o = 1'b1;
                if (load_valid_i) begin
                    if (cnt_q == len_m1) state_d = ST_DONE;
                    else                 cnt_d   = cnt_q + CW'(1);
                end
            end
            ST_DONE: begin
                load_done_o = 1'b1;
                state_d     = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign a_busy  = (state_q == ST_LOAD) && (sel_q == 2'b00);
    assign b_busy  = (state_q == ST_LOAD) && (sel_q == 2'b01);
    assign m_busy  = (state_q == ST_LOAD) && (sel_q == 2'b10);
    assign mp_busy = (state_q == ST_LOAD) && (sel_q == 2'b11);

    // Loads and operand ops never touch the same register in one cycle, so they compose freely.
    always_comb begin
        a_d  = a_q;
        b_d  = b_q;
        m_d  = m_q;
        mp_d = mp_q;
        if (load_beat) begin
            case (sel_q)
                2'b00: begin
                    for (int k = 0; k < NS - 1; k++) a_d[k] = a_q[k+1];
                    a_d[NS-1] = load_data_i;
                end
                2'b01: begin
                    for (int k = 0; k < NS - 1; k++) b_d[k] = b_q[k+1];
                    b_d[NS-1] = load_data_i;
                end
                2'b10: begin
                    for (int k = 0; k < NS - 1; k++) m_d[k] = m_q[k+1];
                    m_d[NS-1] = load_data_i;
                end
                default: begin
                    for (int k = 0; k < N - 1; k++) mp_d[k] = mp_q[k+1];
                    mp_d[N-1] = load_data_i;
                end
            endcase
        end
        if (!a_busy) begin
            for (int j = 0; j < S; j++) begin
                if (A_reg_coeff_rot_i[j]) begin
                    for (int k = 0; k < N; k++) a_d[j*N+k] = a_q[j*N + ((k + 1) % N)];
                end
            end
        end
        if (!b_busy && B_reg_shift_i) begin
            for (int k = 0; k < NS - 1; k++) b_d[k] = b_q[k+1];
            b_d[NS-1] = '0;
        end
        if (!m_busy && M_reg_shift_i) begin
            for (int k = 0; k < NS - 1; k++) m_d[k] = m_q[k+1];
            m_d[NS-1] = '0;
        end
        if (!mp_busy && M_prime_0_rot_i) begin
            for (int k = 0; k < N; k++) mp_d[k] = mp_q[(k + 1) % N];
        end
    end

    assign RES_wr_ready_o = ~full_q[fill_ptr_q];
    assign RES_valid_o    = full_q[drain_ptr_q];
    assign RES_dout_o     = RES_valid_o ? res_q[drain_ptr_q][0] : '0;
    assign RES_last_o     = RES_valid_o && (dcnt_q == CW'(NS - 1));
    assign wr_fire        = RES_wr_en_i && RES_wr_ready_o;
    assign rd_fire        = RES_valid_o && RES_ready_i;

    // A filling buffer is never full and a draining one always is, so the two
    // paths always address different buffers when both fire.
    always_comb begin
        res_d       = res_q;
        full_d      = full_q;
        fill_ptr_d  = fill_ptr_q;
        drain_ptr_d = drain_ptr_q;
        fcnt_d      = fcnt_q;
        dcnt_d      = dcnt_q;
        if (rd_fire) begin
            for (int k = 0; k < NS - 1; k++) res_d[drain_ptr_q][k] = res_q[drain_ptr_q][k+1];
            res_d[drain_ptr_q][NS-1] = '0;
            if (dcnt_q == CW'(NS - 1)) begin
                dcnt_d              = '0;
                full_d[drain_ptr_q] = 1'b0;
                drain_ptr_d         = drain_ptr_q ^ PINGPONG;
            end else begin
                dcnt_d = dcnt_q + CW'(1);
            end
        end
        if (wr_fire) begin
            for (int k = 0; k < NS - 1; k++) res_d[fill_ptr_q][k] = res_q[fill_ptr_q][k+1];
            res_d[fill_ptr_q][NS-1] = RES_din_i;
            if (fcnt_q == CW'(NS - 1)) begin
                fcnt_d             = '0;
                full_d[fill_ptr_q] = 1'b1;
                fill_ptr_d         = fill_ptr_q ^ PINGPONG;
            end else begin
                fcnt_d = fcnt_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            state_q     <= ST_IDLE;
            sel_q       <= '0;
            cnt_q       <= '0;
            full_q      <= '0;
            fill_ptr_q  <= 1'b0;
            drain_ptr_q <= 1'b0;
            fcnt_q      <= '0;
            dcnt_q      <= '0;
            for (int i = 0; i < NS; i++) begin
                a_q[i]      <= '0;
                b_q[i]      <= '0;
                m_q[i]      <= '0;
                res_q[0][i] <= '0;
                res_q[1][i] <= '0;
            end
            for (int i = 0; i < N; i++) mp_q[i] <= '0;
        end else begin
            state_q     <= state_d;
            sel_q       <= sel_d;
            cnt_q       <= cnt_d;
            full_q      <= full_d;
            fill_ptr_q  <= fill_ptr_d;
            drain_ptr_q <= drain_ptr_d;
            fcnt_q      <= fcnt_d;
            dcnt_q      <= dcnt_d;
            a_q         <= a_d;
            b_q         <= b_d;
            m_q         <= m_d;
            mp_q        <= mp_d;
            res_q       <= res_d;
        end
    end

    for (genvar j = 0; j < S; j++) begin : g_a_dout
        assign A_reg_dout_o[j*WORD_WIDTH +: WORD_WIDTH] = a_q[j*N];
    end

    for (genvar l = 0; l < N; l++) begin : g_b_dout
        assign B_reg_dout_o[l*WORD_WIDTH +: WORD_WIDTH] = b_q[l*S];
    end

    assign M_reg_dout_o         = m_q[0];
    assign M_prime_0_reg_dout_o = mp_q[0];

endmodule

// File: tb/tb_poly_reg_bank_stream.sv
// Self-checking bench for poly_reg_bank_stream: queue-based reference model, directed
// scenarios with literal expectations, then randomized traffic compared every cycle.
module tb_poly_reg_bank_stream;
  localparam int W  = 17;
  localparam int N  = 5;
  localparam int S  = 4;
  localparam int NS = N * S;
`ifdef RES_PINGPONG_EN
  localparam bit PP = 1'b1;
`else
  localparam bit PP = 1'b0;
`endif

  logic           clk, rst;
  logic [1:0]     load_sel_i;
  logic           load_start_i, load_valid_i;
  logic [W-1:0]   load_data_i;
  logic           load_ready_o, load_done_o;
  logic [S-1:0]   a_rot_i;
  logic           b_shift_i, m_shift_i, mp_rot_i;
  logic [S*W-1:0] a_dout_o;
  logic [N*W-1:0] b_dout_o;
  logic [W-1:0]   m_dout_o, mp_dout_o;
  logic           res_wr_en_i;
  logic [W-1:0]   res_din_i;
  logic           res_wr_ready_o;
  logic [W-1:0]   res_dout_o;
  logic           res_valid_o, res_ready_i, res_last_o;

  poly_reg_bank_stream dut (
    .clock_i(clk), .reset_i(rst),
    .load_sel_i(load_sel_i), .load_start_i(load_start_i), .load_valid_i(load_valid_i),
    .load_data_i(load_data_i), .load_ready_o(load_ready_o), .load_done_o(load_done_o),
    .A_reg_coeff_rot_i(a_rot_i), .B_reg_shift_i(b_shift_i), .M_reg_shift_i(m_shift_i),
    .M_prime_0_rot_i(mp_rot_i), .A_reg_dout_o(a_dout_o), .B_reg_dout_o(b_dout_o),
    .M_reg_dout_o(m_dout_o), .M_prime_0_reg_dout_o(mp_dout_o),
    .RES_wr_en_i(res_wr_en_i), .RES_din_i(res_din_i), .RES_wr_ready_o(res_wr_ready_o),
    .RES_dout_o(res_dout_o), .RES_valid_o(res_valid_o), .RES_ready_i(res_ready_i),
    .RES_last_o(res_last_o)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      if (n_err <= 40) $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Registers as word queues; word 0 at the front. RES as a stream of completed words.
  logic [W-1:0] qa[$], qb[$], qm[$], qmp[$];
  int           m_phase;   // 0 idle, 1 accepting words, 2 reporting done
  int           m_sel, m_cnt;
  logic [W-1:0] fill_w[$], drain_w[$];
  int           nfull, drained;

  task automatic model_clear();
    qa.delete(); qb.delete(); qm.delete(); qmp.delete();
    for (int i = 0; i < NS; i++) begin qa.push_back('0); qb.push_back('0); qm.push_back('0); end
    for (int i = 0; i < N; i++) qmp.push_back('0);
    m_phase = 0; m_sel = 0; m_cnt = 0;
    fill_w.delete(); drain_w.delete(); nfull = 0; drained = 0;
  endtask

  function automatic bit model_wr_ready();
    return PP ? (nfull < 2) : (nfull == 0);
  endfunction

  task automatic rot_section(int base, int len);
    logic [W-1:0] t;
    t = qa[base];
    for (int k = 0; k < len - 1; k++) qa[base+k] = qa[base+k+1];
    qa[base+len-1] = t;
  endtask

  task automatic model_step();
    bit beat, wr_ok, rd_ok;
    logic [W-1:0] t;
    beat  = (m_phase == 1) && load_valid_i;
    wr_ok = res_wr_en_i && model_wr_ready();
    rd_ok = (nfull > 0) && res_ready_i;
    if (beat) begin
      case (m_sel)
        0: begin void'(qa.pop_front());  qa.push_back(load_data_i);  end
        1: begin void'(qb.pop_front());  qb.push_back(load_data_i);  end
        2: begin void'(qm.pop_front());  qm.push_back(load_data_i);  end
        default: begin void'(qmp.pop_front()); qmp.push_back(load_data_i); end
      endcase
    end
    if (!(m_phase == 1 && m_sel == 0))
      for (int j = 0; j < S; j++) if (a_rot_i[j]) rot_section(j * N, N);
    if (!(m_phase == 1 && m_sel == 1) && b_shift_i) begin void'(qb.pop_front()); qb.push_back('0); end
    if (!(m_phase == 1 && m_sel == 2) && m_shift_i) begin void'(qm.pop_front()); qm.push_back('0); end
    if (!(m_phase == 1 && m_sel == 3) && mp_rot_i) begin t = qmp.pop_front(); qmp.push_back(t); end
    if (m_phase == 0) begin
      if (load_start_i) begin m_phase = 1; m_sel = int'(load_sel_i); m_cnt = 0; end
    end else if (m_phase == 1) begin
      if (beat) begin
        m_cnt++;
        if (m_cnt == ((m_sel == 3) ? N : NS)) m_phase = 2;
      end
    end else begin
      m_phase = 0;
    end
    if (rd_ok) begin
      void'(drain_w.pop_front());
      drained++;
      if (drained == NS) begin nfull--; drained = 0; end
    end
    if (wr_ok) begin
      fill_w.push_back(res_din_i);
      if (fill_w.size() == NS) begin
        foreach (fill_w[i]) drain_w.push_back(fill_w[i]);
        fill_w.delete();
        nfull++;
      end
    end
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) model_clear();
    else     model_step();
  end

  // ---------------- compare process (every cycle) ----------------
  always @(negedge clk) begin
    chk("load_ready", load_ready_o, m_phase == 1);
    chk("load_done", load_done_o, m_phase == 2);
    for (int j = 0; j < S; j++) chk("a_dout", a_dout_o[j*W +: W], qa[j*N]);
    for (int l = 0; l < N; l++) chk("b_dout", b_dout_o[l*W +: W], qb[l*S]);
    chk("m_dout", m_dout_o, qm[0]);
    chk("mp_dout", mp_dout_o, qmp[0]);
    chk("res_wr_ready", res_wr_ready_o, model_wr_ready());
    chk("res_valid", res_valid_o, nfull > 0);
    if (nfull > 0) begin
      chk("res_dout", res_dout_o, drain_w[0]);
      chk("res_last", res_last_o, drained == NS - 1);
    end
  end

  // ---------------- monitors (mid-cycle, inputs and outputs stable) ----------------
  logic [W-1:0] got_q[$];
  logic [W-1:0] exp_q[$];
  int done_cnt = 0;

  always @(negedge clk) begin
    #2;
    if (!rst) begin
      if (load_done_o) done_cnt++;
      if (res_valid_o && res_ready_i) got_q.push_back(res_dout_o);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic load_burst(input logic [1:0] sel, input int base, input bit toggle,
                            input int max_cyc, output int acc);
    bit r;
    load_sel_i   = sel;
    load_start_i = 1'b1;
    @(negedge clk);
    load_start_i = 1'b0;
    acc = 0;
    for (int c = 0; c < max_cyc && acc < NS; c++) begin
      load_valid_i = toggle ? (c % 2 == 0) : 1'b1;
      load_data_i  = W'(base + acc);
      r = load_ready_o;
      @(negedge clk);
      if (load_valid_i && r) acc++;
    end
    load_valid_i = 1'b0;
  endtask

  function automatic logic [W-1:0] a_sec(int j);
    return a_dout_o[j*W +: W];
  endfunction

  function automatic logic [W-1:0] b_sl(int l);
    return b_dout_o[l*W +: W];
  endfunction

  // ---------------- stimulus ----------------
  int acc, k, stalls, cyc;
  int rot_exp[5] = '{11, 12, 13, 14, 10};

  initial begin
    rst = 1'b1;
    load_sel_i = '0; load_start_i = 0; load_valid_i = 0; load_data_i = '0;
    a_rot_i = '0; b_shift_i = 0; m_shift_i = 0; mp_rot_i = 0;
    res_wr_en_i = 0; res_din_i = '0; res_ready_i = 0;
    repeat (3) @(negedge clk);
    chk("rst_wr_ready", res_wr_ready_o, 1);
    chk("rst_load_ready", load_ready_o, 0);
    chk("rst_res_valid", res_valid_o, 0);
    chk("rst_a_dout", a_dout_o, 0);
    #1 rst = 1'b0;
    @(negedge clk);

    // Load A = 0..19 with valid toggling
    done_cnt = 0;
    load_burst(2'b00, 0, 1'b1, 60, acc);
    repeat (2) @(negedge clk);
    chk("a_beats", acc, 20);
    chk("a_done_pulses", done_cnt, 1);
    chk("a_sec0", a_sec(0), 0);
    chk("a_sec2", a_sec(2), 10);
    chk("a_sec3", a_sec(3), 15);

    // Rotate section 2 five times
    for (int i = 0; i < 5; i++) begin
      a_rot_i = 4'b0100;
      @(negedge clk);
      a_rot_i = 4'b0000;
      chk("rot_sec2", a_sec(2), rot_exp[i]);
      chk("rot_sec1", a_sec(1), 5);
    end

    // Load B = 0..19, shift 3 times, then once more
    load_burst(2'b01, 0, 1'b0, 40, acc);
    repeat (2) @(negedge clk);
    b_shift_i = 1'b1;
    repeat (3) @(negedge clk);
    b_shift_i = 1'b0;
    for (int l = 0; l < N; l++) chk("b_shift3", b_sl(l), l * 4 + 3);
    b_shift_i = 1'b1;
    @(negedge clk);
    b_shift_i = 1'b0;
    chk("b_shift4_top", b_sl(4), 0);
    chk("b_shift4_s0", b_sl(0), 4);

    // Load M_prime_0 with valid held high: only N beats taken
    done_cnt = 0;
    load_burst(2'b11, 30, 1'b0, 12, acc);
    repeat (2) @(negedge clk);
    chk("mp_beats", acc, 5);
    chk("mp_done_pulses", done_cnt, 1);
    chk("mp_dout", mp_dout_o, 30);
    chk("mp_a_untouched", a_sec(2), 10);
    chk("mp_b_untouched", b_sl(1), 8);
    chk("mp_m_untouched", m_dout_o, 0);

    // RES: fill 100..119, then drain with stalls while 200..219 is offered
    for (int i = 0; i < NS; i++) begin
      res_wr_en_i = 1'b1; res_din_i = W'(100 + i);
      @(negedge clk);
    end
    res_wr_en_i = 1'b0;
    got_q.delete();
    k = 0; stalls = 0; cyc = 0;
    while (cyc < 300 && !(k == NS && got_q.size() == 2 * NS)) begin
      res_ready_i = (cyc % 3 != 2);
      res_wr_en_i = (k < NS);
      res_din_i   = W'(200 + k);
      if (res_wr_en_i && !res_wr_ready_o) stalls++;
      if (res_wr_en_i && res_wr_ready_o) k++;
      @(negedge clk);
      cyc++;
    end
    res_ready_i = 1'b0; res_wr_en_i = 1'b0;
    @(negedge clk);
    chk("res_loop_bound", cyc < 300, 1);
    for (int i = 0; i < NS; i++) exp_q.push_back(W'(100 + i));
    for (int i = 0; i < NS; i++) exp_q.push_back(W'(200 + i));
    chk("res_count", got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) chk("res_order", got_q[i], exp_q[i]);
    if (PP) chk("res_pp_stalls", stalls, 0);
    else    chk("res_single_stalled", stalls > 0, 1);
    chk("res_idle_after", res_valid_o, 0);

    // Reset in the middle of a load of A
    load_burst(2'b00, 50, 1'b0, 7, acc);
    chk("mid_beats", acc, 7);
    #1 rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_ready", load_ready_o, 0);
    chk("mid_rst_a", a_sec(0), 0);
    chk("mid_rst_wr_ready", res_wr_ready_o, 1);
    #1 rst = 1'b0;
    @(negedge clk);
    done_cnt = 0;
    load_burst(2'b00, 0, 1'b0, 40, acc);
    repeat (2) @(negedge clk);
    chk("reload_beats", acc, 20);
    chk("reload_done", done_cnt, 1);
    chk("reload_sec1", a_sec(1), 5);
    chk("reload_sec3", a_sec(3), 15);

    // Randomized traffic, checked every cycle by the compare process
    for (int c = 0; c < 3000; c++) begin
      load_start_i = ($urandom_range(0, 15) == 0);
      load_sel_i   = 2'($urandom_range(0, 3));
      load_valid_i = ($urandom_range(0, 2) != 0);
      load_data_i  = W'($urandom_range(0, (1 << W) - 1));
      a_rot_i      = ($urandom_range(0, 3) == 0) ? S'($urandom_range(0, 15)) : '0;
      b_shift_i    = ($urandom_range(0, 5) == 0);
      m_shift_i    = ($urandom_range(0, 5) == 0);
      mp_rot_i     = ($urandom_range(0, 5) == 0);
      res_wr_en_i  = ($urandom_range(0, 3) != 0);
      res_din_i    = W'($urandom_range(0, (1 << W) - 1));
      res_ready_i  = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 799) == 0) begin
        #1 rst = 1'b1;
        @(negedge clk);
        #1 rst = 1'b0;
      end
      @(negedge clk);
    end
    load_start_i = 0; load_valid_i = 0; a_rot_i = '0; b_shift_i = 0; m_shift_i = 0;
    mp_rot_i = 0; res_wr_en_i = 0; res_ready_i = 0;
    repeat (3) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  initial begin
    #1_000_000;
    n_err++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $fatal(1, "watchdog");
  end
endmodule
